lcm_eg9013f_scan_engine: RTL
============================

LCM_EG9013F_SCAN_ENGINE -- requirements
Module: lcm_eg9013f_scan_engine

Interface
REQ-001 SHALL have parameter BYTE_WIDTH, default 8: pixel bytes per panel data transfer.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: frame RAM read address width.
REQ-003 SHALL have parameter H_BYTES, default 80: bytes per panel line.
REQ-004 SHALL have parameter V_LINES, default 240: lines per frame.
REQ-005 SHALL have parameter XSCL_DIV, default 4, minimum 2: clk cycles per XSCL half-period.
REQ-006 SHALL have parameter LP_WIDTH, default 4: clk cycles LP is held high.
REQ-007 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port enable, input, 1 bit: level; allows a frame to start.
REQ-010 SHALL have port rd_en, output, 1 bit: frame RAM read strobe.
REQ-011 SHALL have port rd_addr, output, ADDR_WIDTH bits: frame RAM byte address.
REQ-012 SHALL have port rd_data, input, BYTE_WIDTH bits: RAM data, valid 1 cycle after rd_en.
REQ-013 SHALL have port lcm_din, output, 1 bit: frame start marker (FLM).
REQ-014 SHALL have port lcm_lp, output, 1 bit: line latch pulse.
REQ-015 SHALL have port lcm_xscl, output, 1 bit: data shift clock; the panel samples on the falling edge.
REQ-016 SHALL have port lcm_data, output, BYTE_WIDTH bits: panel data bus.
REQ-017 SHALL have port busy, output, 1 bit: high while FSM is not IDLE.
REQ-018 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-019 FSM SHALL have the states IDLE, SHIFT and LPULSE, and SHALL behave as follows.
- IDLE -> SHIFT the cycle after enable=1 is sampled.
- SHIFT -> LPULSE after H_BYTES byte slots.
- LPULSE -> SHIFT after LP_WIDTH cycles if lines remain.
- After the last line's LPULSE: frame_done pulses; go to SHIFT if enable=1, else IDLE.
REQ-020 Each byte slot SHALL be 2*XSCL_DIV cycles long, counted 0..2*XSCL_DIV-1.
- Slot cycle 0: rd_en=1, with rd_addr = line*H_BYTES + byte.
- Slot cycle 1: rd_data is registered into lcm_data.
- lcm_xscl is high for slot cycles XSCL_DIV..2*XSCL_DIV-1 and low otherwise.
REQ-021 In LPULSE, lcm_lp SHALL be 1, lcm_xscl 0, rd_en 0, and lcm_data SHALL hold its last value.
REQ-022 lcm_din SHALL be 1 from the first SHIFT cycle of line 0 through the end of line 0's LPULSE, and 0 otherwise.
REQ-023 The byte and line counters SHALL wrap to 0 at H_BYTES-1 and V_LINES-1; rd_addr SHALL be 0 at each frame start.
REQ-024 enable deasserted mid-frame SHALL NOT abort: the current frame completes, then the FSM goes to IDLE.
REQ-025 In IDLE: rd_en=0, and lcm_xscl, lcm_lp, lcm_din all 0.
REQ-026 Address arithmetic SHALL be unsigned; H_BYTES*V_LINES ≤ 2**ADDR_WIDTH is a parameter-legality requirement.

Reset
REQ-027 While rst=1, the FSM SHALL go to IDLE, counters to 0, and all outputs to 0 (including lcm_data, busy and frame_done), effective at the next clk edge.
REQ-028 rst asserted mid-line SHALL discard the partial frame; the next frame starts from address 0.

Configuration
REQ-029 With LCM_DATA_REVERSE_EN defined, lcm_data SHALL be the bit-reversed registered rd_data (bit i <- bit BYTE_WIDTH-1-i).
REQ-030 Without LCM_DATA_REVERSE_EN, lcm_data SHALL be rd_data unmodified; timing SHALL be identical in both builds.

Structure
REQ-031 Package lcm_eg9013f_pkg SHALL hold the FSM state enum and the default timing constants (H_BYTES, V_LINES, XSCL_DIV, LP_WIDTH).
REQ-032 Sub-module lcm_slot_timer SHALL generate the slot cycle count and the slot_start/slot_end ticks; all remaining logic lives in the top module.

Verification (H_BYTES=4, V_LINES=3, XSCL_DIV=2, LP_WIDTH=2 unless stated)
REQ-033 Scenario: enable=1 held, RAM[i]=i.
- Expected: rd_addr sequence 0..11, then wrap to 0.
- Expected: lcm_data 0x00..0x0B, each stable across its xscl falling edge.
- Expected: frame_done pulses every 3*(4*4+2)=54 cycles.
REQ-034 Scenario: LP/DIN check.
- Expected: lcm_lp high for exactly 2 cycles after every 16 SHIFT cycles.
- Expected: lcm_din high for cycles 1..18 of each frame only.
REQ-035 Scenario: enable dropped at line 1, byte 2.
- Expected: lines 1–2 complete, frame_done pulses, then busy=0.
- Expected: no further rd_en.
REQ-036 Scenario: rst pulsed at line 2, byte 1.
- Expected: outputs 0 the next cycle.
- Expected: after release with enable=1, the first rd_addr is 0.
REQ-037 Scenario: build with LCM_DATA_REVERSE_EN, RAM[0]=0x01.
- Expected: lcm_data=0x80.
- Expected: without the macro, lcm_data=0x01.
REQ-038 Scenario: XSCL_DIV=3.
- Expected: the xscl period is 6 cycles with a 3/3 duty.
- Expected: rd_en is asserted exactly once per slot.

Source files
------------

// File: rtl/lcm_eg9013f_pkg.sv
// Shared types, default timing constants and width helper for the EG9013F scan engine.
package lcm_eg9013f_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        LPULSE = 2'd2
    } state_t;

    localparam int unsigned DEF_BYTE_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 16;
    localparam int unsigned DEF_H_BYTES    = 80;
    localparam int unsigned DEF_V_LINES    = 240;
    localparam int unsigned DEF_XSCL_DIV   = 4;
    localparam int unsigned DEF_LP_WIDTH   = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcm_slot_timer.sv
// Byte-slot cycle counter: runs 0..2*XSCL_DIV-1 while run is high, idles at 0 otherwise.
module lcm_slot_timer
    import lcm_eg9013f_pkg::*;
#(
    parameter int unsigned XSCL_DIV = DEF_XSCL_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic slot_start_c,
    output logic slot_end_c,
    output logic xscl_hi_c
);

    localparam int unsigned SLOT_LEN = 2 * XSCL_DIV;
    localparam int unsigned CW       = cnt_w(SLOT_LEN);

    logic [CW-1:0] slot_cnt;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            slot_cnt <= '0;
        end else if (slot_cnt == CW'(SLOT_LEN - 1)) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

    assign slot_start_c = run && (slot_cnt == '0);
    assign slot_end_c   = run && (slot_cnt == CW'(SLOT_LEN - 1));
    assign xscl_hi_c    = run && (slot_cnt >= CW'(XSCL_DIV));

endmodule

// File: rtl/lcm_eg9013f_scan_engine.sv
// EG9013F LCD scan engine: reads the frame RAM and drives FLM/LP/XSCL/data to the panel.
// Optional macro LCM_DATA_REVERSE_EN bit-reverses each byte presented on lcm_data.
module lcm_eg9013f_scan_engine
    import lcm_eg9013f_pkg::*;
#(
    parameter int unsigned BYTE_WIDTH = DEF_BYTE_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned H_BYTES    = DEF_H_BYTES,
    parameter int unsigned V_LINES    = DEF_V_LINES,
    parameter int unsigned XSCL_DIV   = DEF_XSCL_DIV,
    parameter int unsigned LP_WIDTH   = DEF_LP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [BYTE_WIDTH-1:0] rd_data,
    output logic                  lcm_din,
    output logic                  lcm_lp,
    output logic                  lcm_xscl,
    output logic [BYTE_WIDTH-1:0] lcm_data,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned BCW = cnt_w(H_BYTES);
    localparam int unsigned LCW = cnt_w(V_LINES);
    localparam int unsigned PCW = cnt_w(LP_WIDTH);

    state_t                state_q, state_d;
    logic [BCW-1:0]        byte_q;
    logic [LCW-1:0]        line_q;
    logic [PCW-1:0]        lp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_valid_q;

    logic run_c, slot_start_c, slot_end_c, xscl_hi_c;
    logic last_byte_c, last_line_c, lp_last_c, frame_end_c;
    logic rd_en_d, lp_d, xscl_d, din_d, busy_d, frame_done_d;
    logic [BYTE_WIDTH-1:0] data_fmt_c;

    assign run_c = (state_q == SHIFT);

    lcm_slot_timer #(
        .XSCL_DIV (XSCL_DIV)
    ) u_slot_timer (
        .clk          (clk),
        .rst          (rst),
        .run          (run_c),
        .slot_start_c (slot_start_c),
        .slot_end_c   (slot_end_c),
        .xscl_hi_c    (xscl_hi_c)
    );

    assign last_byte_c = (byte_q == BCW'(H_BYTES - 1));
    assign last_line_c = (line_q == LCW'(V_LINES - 1));
    assign lp_last_c   = (lp_q == PCW'(LP_WIDTH - 1));
    assign frame_end_c = (state_q == LPULSE) && lp_last_c && last_line_c;

`ifdef LCM_DATA_REVERSE_EN
    always_comb begin
        data_fmt_c = '0;
        for (int i = 0; i < int'(BYTE_WIDTH); i++) begin
            data_fmt_c[i] = rd_data[BYTE_WIDTH-1-i];
        end
    end
`else
    assign data_fmt_c = rd_data;
`endif

    // Next state and next registered output values.
    always_comb begin
        state_d      = state_q;
        rd_en_d      = slot_start_c;
        xscl_d       = xscl_hi_c;
        lp_d         = (state_q == LPULSE);
        din_d        = (state_q != IDLE) && (line_q == '0);
        busy_d       = (state_q != IDLE);
        frame_done_d = frame_end_c;
        case (state_q)
            IDLE:    if (enable) state_d = SHIFT;
            SHIFT:   if (slot_end_c && last_byte_c) state_d = LPULSE;
            LPULSE:  if (lp_last_c) state_d = (!last_line_c || enable) ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            line_q     <= '0;
            lp_q       <= '0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            lcm_din    <= 1'b0;
            lcm_lp     <= 1'b0;
            lcm_xscl   <= 1'b0;
            lcm_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_en      <= rd_en_d;
            lcm_din    <= din_d;
            lcm_lp     <= lp_d;
            lcm_xscl   <= xscl_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            rd_valid_q <= rd_en;

            if (slot_end_c) begin
                byte_q <= last_byte_c ? '0 : byte_q + BCW'(1);
                addr_q <= (last_byte_c && last_line_c) ? '0 : addr_q + ADDR_WIDTH'(1);
            end

            if (state_q == LPULSE) begin
                lp_q <= lp_last_c ? '0 : lp_q + PCW'(1);
                if (lp_last_c) line_q <= last_line_c ? '0 : line_q + LCW'(1);
            end else begin
                lp_q <= '0;
            end

            if (slot_start_c) rd_addr <= addr_q;
            // rd_data answers the strobe seen on the previous cycle.
            if (rd_valid_q) lcm_data <= data_fmt_c;
        end
    end

endmodule
